seq_stream_ctrl: RTL and testbench

Frame-oriented controller that feeds the bit-serial "1011" sequence detector from a byte stream. It accepts bytes over a valid/ready handshake and serializes them MSB-first onto the detector input, one bit per clock. It also counts detector hits, records the frame bit index of the first hit, flushes the detector between frames, and returns one result record per frame over a second valid/ready handshake.

---
 rtl/seq_stream_ctrl.sv | 167 ++++++++++++++++
 tb/tb_seq_stream_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_stream_ctrl.sv
// Byte-stream front end for the serial "1011" detector: serializes frames,
// counts detector hits, flushes between frames and returns one record per frame.
module seq_stream_ctrl #(
    parameter int CNT_W = 8,
    parameter int POS_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       s_data,
    input  logic             s_last,
    input  logic             s_valid,
    output logic             s_ready,
    output logic             det_bit,
    input  logic             det_hit,
    output logic [CNT_W-1:0] res_count,
    output logic [POS_W-1:0] res_first_pos,
    output logic             res_found,
    output logic             res_err,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             busy
);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        DISCARD,
        FLUSH0,
        FLUSH1,
        REPORT
    } state_t;

    state_t state, state_nx;

    logic [7:0]       pend;
    logic             pend_last;
    logic             pend_valid;
    logic [7:0]       shreg;
    logic [2:0]       bit_cnt;
    logic             cur_last;
    logic [POS_W-1:0] idx;
    logic [POS_W-1:0] bit_pos;
    logic [CNT_W-1:0] count;
    logic [POS_W-1:0] first_pos;
    logic             err;
    logic             inflight;

    logic accept;
    logic load;
    logic start;
    logic underrun;
    logic byte_end;

    assign accept   = s_valid && s_ready;
    assign start    = (state == IDLE) && pend_valid;
    assign byte_end = (state == SHIFT) && (bit_cnt == 3'd7);
    assign underrun = byte_end && !cur_last && !pend_valid;

    always_comb begin
        state_nx = state;
        s_ready  = 1'b0;
        det_bit  = 1'b0;
        load     = 1'b0;
        unique case (state)
            IDLE: begin
                s_ready = !pend_valid;
                if (pend_valid) begin
                    load     = 1'b1;
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                s_ready = !pend_valid;
                det_bit = shreg[7];
                if (bit_cnt == 3'd7) begin
                    if (cur_last)        state_nx = FLUSH0;
                    else if (pend_valid) load     = 1'b1;
                    else                 state_nx = DISCARD;
                end
            end
            DISCARD: begin
                s_ready = 1'b1;
                // A last byte ends the aborted frame whether pending or arriving now
                if ((pend_valid && pend_last) || (s_valid && s_last))
                    state_nx = FLUSH0;
            end
            FLUSH0:  state_nx = FLUSH1;
            FLUSH1:  state_nx = REPORT;
            REPORT: begin
                if (res_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend       <= '0;
            pend_last  <= 1'b0;
            pend_valid <= 1'b0;
        end else if (load || state == DISCARD) begin
            pend_valid <= 1'b0;
        end else if (accept) begin
            pend       <= s_data;
            pend_last  <= s_last;
            pend_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg    <= '0;
            bit_cnt  <= '0;
            cur_last <= 1'b0;
        end else if (load) begin
            shreg    <= pend;
            cur_last <= pend_last;
            bit_cnt  <= '0;
        end else if (state == SHIFT) begin
            shreg   <= {shreg[6:0], 1'b0};
            bit_cnt <= bit_cnt + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            bit_pos   <= '0;
            count     <= '0;
            first_pos <= '0;
            err       <= 1'b0;
            inflight  <= 1'b0;
        end else begin
            inflight <= (state == SHIFT);
            if (start) begin
                idx       <= '0;
                count     <= '0;
                first_pos <= '0;
                err       <= 1'b0;
            end else begin
                if (state == SHIFT) begin
                    bit_pos <= idx;
                    if (idx != '1) idx <= idx + 1'b1;
                end
                // det_hit belongs to the bit driven one cycle earlier
                if (inflight && det_hit) begin
                    if (count != '1) count <= count + 1'b1;
                    if (count == '0) first_pos <= bit_pos;
                end
                if (underrun) err <= 1'b1;
            end
        end
    end

    assign res_count     = count;
    assign res_first_pos = first_pos;
    assign res_found     = (count != '0);
    assign res_err       = err;
    assign res_valid     = (state == REPORT);
    assign busy          = (state != IDLE);

endmodule

// File: tb/tb_seq_stream_ctrl.sv
// Randomized and directed bench for seq_stream_ctrl with an external
// "1011" detector and a frame-level bit-pattern reference model.
module tb_seq_stream_ctrl;

    localparam int LOGN = 16384;

    typedef struct {
        int cnt;
        int pos;
        bit err;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [7:0]  s_data;
    logic        s_last;
    logic        s_valid;
    logic        s_ready;
    logic        det_bit;
    logic        det_hit;
    logic [7:0]  res_count;
    logic [15:0] res_first_pos;
    logic        res_found;
    logic        res_err;
    logic        res_valid;
    logic        res_ready;
    logic        busy;

    seq_stream_ctrl #(.CNT_W(8), .POS_W(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_data        (s_data),
        .s_last        (s_last),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .det_bit       (det_bit),
        .det_hit       (det_hit),
        .res_count     (res_count),
        .res_first_pos (res_first_pos),
        .res_found     (res_found),
        .res_err       (res_err),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .busy          (busy)
    );

    // Moore "1011" detector, overlapping, sharing the controller reset
    logic [3:0] hist;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) hist <= 4'b0;
        else        hist <= {hist[2:0], det_bit};
    end
    assign det_hit = (hist == 4'b1011);

    int   n_chk;
    int   n_pass;
    int   cyc;
    int   acc0;
    bit   rr_force;
    bit   rr_val;
    exp_t expq[$];
    exp_t mon_e;
    bit   det_log [LOGN];
    bit   rv_log  [LOGN];
    logic [7:0] fr [8];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    function automatic exp_t ref_frame(input logic [7:0] d [8], input int n,
                                       input bit e);
        bit   b [64];
        int   nb;
        exp_t r;
        nb    = 0;
        r.cnt = 0;
        r.pos = 0;
        r.err = e;
        for (int i = 0; i < n; i++)
            for (int k = 7; k >= 0; k--) begin
                b[nb] = d[i][k];
                nb++;
            end
        for (int j = 3; j < nb; j++)
            if (b[j-3] && !b[j-2] && b[j-1] && b[j]) begin
                if (r.cnt == 0) r.pos = j;
                if (r.cnt < 255) r.cnt++;
            end
        return r;
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        res_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            res_ready = rr_force ? rr_val : ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            det_log[cyc % LOGN] = det_bit;
            rv_log[cyc % LOGN]  = res_valid;
            if (rst_n && res_valid && res_ready) begin
                if (expq.size() == 0) begin
                    check("unexpected_record", 32'(res_count), 32'hdead);
                end else begin
                    mon_e = expq.pop_front();
                    check("res_count", 32'(res_count), 32'(mon_e.cnt));
                    check("res_first_pos", 32'(res_first_pos), 32'(mon_e.pos));
                    check("res_found", 32'(res_found), 32'(mon_e.cnt != 0));
                    check("res_err", 32'(res_err), 32'(mon_e.err));
                end
            end
        end
    end

    task automatic send_frame(input logic [7:0] d [8], input int n,
                              input int gap_at, input int gap_len);
        bit ok;
        int t;
        @(posedge clk);
        #1;
        for (int i = 0; i < n; i++) begin
            s_data  = d[i];
            s_last  = (i == n - 1);
            s_valid = 1'b1;
            ok = 1'b0;
            t  = 0;
            while (!ok && t < 500) begin
                @(negedge clk);
                ok = s_ready;
                t++;
            end
            if (!ok) check("accept_timeout", 32'(s_ready), 32'd1);
            if (i == 0) acc0 = cyc + 1;
            @(posedge clk);
            #1;
            s_valid = 1'b0;
            if (i == gap_at) begin
                repeat (gap_len) @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((expq.size() != 0 || busy) && t < 4000) begin
            @(posedge clk);
            t++;
        end
        if (t >= 4000) check("drain_timeout", 32'(expq.size()), 32'd0);
        repeat (2) @(posedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s_ready"}, 32'(s_ready), 32'd1);
        check({tag, "_det_bit"}, 32'(det_bit), 32'd0);
        check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_res_count"}, 32'(res_count), 32'd0);
        check({tag, "_first_pos"}, 32'(res_first_pos), 32'd0);
        check({tag, "_found"}, 32'(res_found), 32'd0);
        check({tag, "_err"}, 32'(res_err), 32'd0);
    endtask

    initial begin
        int   a;
        int   t;
        int   n;
        logic [15:0] w;
        logic [7:0]  cap_cnt;
        logic [15:0] cap_pos;
        n_chk    = 0;
        n_pass   = 0;
        rr_force = 1'b1;
        rr_val   = 1'b1;
        rst_n    = 1'b0;
        s_data   = 8'h00;
        s_last   = 1'b0;
        s_valid  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("reset");

        // single byte, one hit, plus latency and bit order
        fr[0] = 8'hB0;
        expq.push_back(ref_frame(fr, 1, 1'b0));
        send_frame(fr, 1, -1, 0);
        a = acc0;
        drain();
        check("b0_rv_early", 32'(rv_log[(a + 10) % LOGN]), 32'd0);
        check("b0_rv_rise", 32'(rv_log[(a + 11) % LOGN]), 32'd1);
        for (int i = 0; i < 8; i++)
            check("b0_det_bit", 32'(det_log[(a + 1 + i) % LOGN]),
                  32'(fr[0][7 - i]));

        // overlapping hits
        fr[0] = 8'h5B;
        expq.push_back(ref_frame(fr, 1, 1'b0));
        send_frame(fr, 1, -1, 0);
        drain();

        // match across a byte boundary, no bubble between bytes
        fr[0] = 8'h01;
        fr[1] = 8'h60;
        expq.push_back(ref_frame(fr, 2, 1'b0));
        send_frame(fr, 2, -1, 0);
        a = acc0;
        drain();
        w = {fr[0], fr[1]};
        for (int i = 0; i < 16; i++)
            check("xbyte_det_bit", 32'(det_log[(a + 1 + i) % LOGN]),
                  32'(w[15 - i]));

        // two consecutive frames, no hit across the boundary
        fr[0] = 8'hB0;
        fr[1] = 8'h00;
        fr[2] = 8'h0B;
        expq.push_back(ref_frame(fr, 3, 1'b0));
        send_frame(fr, 3, -1, 0);
        fr[0] = 8'h0B;
        expq.push_back(ref_frame(fr, 1, 1'b0));
        send_frame(fr, 1, -1, 0);
        drain();

        // underrun after byte 0: later bytes dropped, in-flight hit kept
        fr[0] = 8'h5B;
        fr[1] = 8'hBB;
        fr[2] = 8'hBB;
        expq.push_back(ref_frame(fr, 1, 1'b1));
        send_frame(fr, 3, 0, 10);
        drain();

        // consumer stalls: record and outputs hold
        rr_val = 1'b0;
        fr[0]  = 8'h2D;
        expq.push_back(ref_frame(fr, 1, 1'b0));
        send_frame(fr, 1, -1, 0);
        t = 0;
        while (!res_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("hold_rv_seen", 32'(res_valid), 32'd1);
        cap_cnt = res_count;
        cap_pos = res_first_pos;
        check("hold_cnt_val", 32'(cap_cnt), 32'd1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("hold_res_valid", 32'(res_valid), 32'd1);
            check("hold_s_ready", 32'(s_ready), 32'd0);
            check("hold_det_bit", 32'(det_bit), 32'd0);
            check("hold_count", 32'(res_count), 32'(cap_cnt));
            check("hold_pos", 32'(res_first_pos), 32'(cap_pos));
        end
        rr_val = 1'b1;
        drain();

        // asynchronous reset in the middle of shifting
        fr[0] = 8'hFF;
        send_frame(fr, 1, -1, 0);
        a = acc0;
        while (cyc < a + 4) @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'd1);
        check("pre_rst_det_bit", 32'(det_bit), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        check("midrst_no_record", 32'(expq.size()), 32'd0);

        // recovery after reset
        fr[0] = 8'hB0;
        expq.push_back(ref_frame(fr, 1, 1'b0));
        send_frame(fr, 1, -1, 0);
        drain();

        // random frames with random consumer back-pressure
        rr_force = 1'b0;
        for (int f = 0; f < 40; f++) begin
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) fr[i] = 8'($urandom);
            expq.push_back(ref_frame(fr, n, 1'b0));
            send_frame(fr, n, -1, 0);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
